// File: rtl/debounce_pkg.sv
// Shared constants and types for the multi-channel debouncer.
// Defaults assume a 1 MHz filtering rate, so 20000 ticks give a 20 ms settle window.
package debounce_pkg;

    localparam int   BOARD_CLK_HZ          = 1_000_000;
    localparam int   DEBOUNCE_MS           = 20;
    localparam int   DEFAULT_STABLE_CYCLES = (BOARD_CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int   DEFAULT_SYNC_STAGES   = 2;

    // Pads idle low by default; active-low keys idle high and want INIT_LEVEL = 1.
    localparam logic DEFAULT_INIT_LEVEL    = 1'b0;
    localparam logic ACTIVE_LOW_INIT_LEVEL = 1'b1;

    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } chan_out_t;

    function automatic int cnt_width(input int stable_cycles);
        return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer bit: synchroniser chain, mismatch counter, and registered
// level plus single-cycle rise/fall pulses.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic INIT_LEVEL    = DEFAULT_INIT_LEVEL
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic in_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int             CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    chan_out_t              out_q;
    chan_out_t              out_d;
    logic                   sample;

    assign sample = sync_q[SYNC_STAGES-1];

    // The synchroniser runs every clock; only the qualification counter honours tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{INIT_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            out_q <= '{level: INIT_LEVEL, rise: 1'b0, fall: 1'b0};
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    // A match clears progress immediately, even between ticks, so any bounce restarts the count.
    always_comb begin
        cnt_d      = cnt_q;
        out_d      = out_q;
        out_d.rise = 1'b0;
        out_d.fall = 1'b0;
        if (sample == out_q.level) begin
            cnt_d = '0;
        end else if (tick_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d       = '0;
                out_d.level = sample;
                out_d.rise  = sample;
                out_d.fall  = ~sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign level_o = out_q.level;
    assign rise_o  = out_q.rise;
    assign fall_o  = out_q.fall;

endmodule

// File: rtl/debounce_multi.sv
// N independent debounce channels between raw pads and the key-event consumers.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   CHANNELS      = 4,
    parameter int   SYNC_STAGES   = DEFAULT_SYNC_STAGES,
    parameter int   STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter logic INIT_LEVEL    = DEFAULT_INIT_LEVEL
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tick_i,
    input  logic [CHANNELS-1:0] in_signal_i,
    output logic [CHANNELS-1:0] out_level_o,
    output logic [CHANNELS-1:0] out_rise_o,
    output logic [CHANNELS-1:0] out_fall_o
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES  (SYNC_STAGES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .INIT_LEVEL   (INIT_LEVEL)
        ) u_chan (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .tick_i (tick_i),
            .in_i   (in_signal_i[i]),
            .level_o(out_level_o[i]),
            .rise_o (out_rise_o[i]),
            .fall_o (out_fall_o[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench: a 4-channel, 8-cycle instance and a 1-channel, 1-cycle,
// 3-stage, idle-high instance sharing clock, reset and tick.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic [3:0] inSig;
    logic [3:0] outLevel;
    logic [3:0] outRise;
    logic [3:0] outFall;
    logic [0:0] in1;
    logic [0:0] level1;
    logic [0:0] rise1;
    logic [0:0] fall1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .CHANNELS     (4),
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(8),
        .INIT_LEVEL   (1'b0)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tick_i     (tick),
        .in_signal_i(inSig),
        .out_level_o(outLevel),
        .out_rise_o (outRise),
        .out_fall_o (outFall)
    );

    debounce_multi #(
        .CHANNELS     (1),
        .SYNC_STAGES  (3),
        .STABLE_CYCLES(1),
        .INIT_LEVEL   (1'b1)
    ) dutAux (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .tick_i     (tick),
        .in_signal_i(in1),
        .out_level_o(level1),
        .out_rise_o (rise1),
        .out_fall_o (fall1)
    );

    // Advance n clocks and leave the bench 1 ns past the last rising edge.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Vectors are {level, rise, fall}; the aux instance occupies the low 3 bits.
    task automatic checkOutput(input string tag, input logic [11:0] observed,
                               input logic [11:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [11:0] mainVec();
        return {outLevel, outRise, outFall};
    endfunction

    function automatic logic [11:0] auxVec();
        return {9'd0, level1, rise1, fall1};
    endfunction

    initial begin
        rst_n = 1'b0;
        tick  = 1'b1;
        inSig = 4'h0;
        in1   = 1'b1;

        $display("[TB] reset with toggling inputs");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1);
            inSig = ~inSig;
            in1   = ~in1;
            checkOutput("rst_main", mainVec(), 12'h000);
            checkOutput("rst_aux", auxVec(), 12'h004);
        end
        applyStimulus(1);
        rst_n = 1'b1;
        applyStimulus(12);
        checkOutput("post_release_main", mainVec(), 12'h000);
        checkOutput("post_release_aux", auxVec(), 12'h004);

        $display("[TB] clean rising edge on channel 0");
        inSig = 4'b0001;
        applyStimulus(9);
        checkOutput("clean_before", mainVec(), 12'h000);
        applyStimulus(1);
        checkOutput("clean_flip", mainVec(), 12'h110);
        applyStimulus(1);
        checkOutput("clean_after", mainVec(), 12'h100);

        $display("[TB] bouncing channel 1");
        for (int seg = 0; seg < 10; seg++) begin
            inSig[1] = (seg % 2 == 0);
            for (int c = 0; c < 3; c++) begin
                applyStimulus(1);
                checkOutput("bounce_quiet", mainVec(), 12'h100);
            end
        end
        inSig[1] = 1'b1;
        applyStimulus(9);
        checkOutput("bounce_before", mainVec(), 12'h100);
        applyStimulus(1);
        checkOutput("bounce_flip", mainVec(), 12'h320);
        applyStimulus(1);
        checkOutput("bounce_after", mainVec(), 12'h300);

        $display("[TB] tick every 4th clock on channel 2");
        inSig[2] = 1'b1;
        tick     = 1'b0;
        for (int j = 1; j <= 33; j++) begin
            applyStimulus(1);
            if (j == 31) checkOutput("tick_before", mainVec(), 12'h300);
            if (j == 32) checkOutput("tick_flip", mainVec(), 12'h740);
            if (j == 33) checkOutput("tick_after", mainVec(), 12'h700);
            tick = (j % 4 == 3);
        end

        $display("[TB] tick held low on channel 3");
        tick     = 1'b0;
        inSig[3] = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1);
            checkOutput("tick_frozen", mainVec(), 12'h700);
        end
        tick = 1'b1;
        applyStimulus(7);
        checkOutput("tick_resume_before", mainVec(), 12'h700);
        applyStimulus(1);
        checkOutput("tick_resume_flip", mainVec(), 12'hF80);
        applyStimulus(1);
        checkOutput("tick_resume_after", mainVec(), 12'hF00);

        $display("[TB] simultaneous fall on all channels");
        inSig = 4'h0;
        applyStimulus(9);
        checkOutput("all_before", mainVec(), 12'hF00);
        applyStimulus(1);
        checkOutput("all_flip", mainVec(), 12'h00F);
        applyStimulus(1);
        checkOutput("all_after", mainVec(), 12'h000);

        $display("[TB] reset in the middle of filtering");
        inSig = 4'b0001;
        applyStimulus(8);
        checkOutput("midrst_before", mainVec(), 12'h000);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_assert", mainVec(), 12'h000);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("midrst_hold", mainVec(), 12'h000);
        end
        rst_n = 1'b1;
        applyStimulus(9);
        checkOutput("midrst_before_flip", mainVec(), 12'h000);
        applyStimulus(1);
        checkOutput("midrst_flip", mainVec(), 12'h110);
        applyStimulus(1);
        checkOutput("midrst_after", mainVec(), 12'h100);

        $display("[TB] single-cycle qualification on aux instance");
        checkOutput("aux_idle", auxVec(), 12'h004);
        in1 = 1'b0;
        applyStimulus(3);
        checkOutput("aux_fall_before", auxVec(), 12'h004);
        applyStimulus(1);
        checkOutput("aux_fall_flip", auxVec(), 12'h001);
        applyStimulus(1);
        checkOutput("aux_fall_after", auxVec(), 12'h000);
        in1 = 1'b1;
        applyStimulus(3);
        checkOutput("aux_rise_before", auxVec(), 12'h000);
        applyStimulus(1);
        checkOutput("aux_rise_flip", auxVec(), 12'h006);
        applyStimulus(1);
        checkOutput("aux_rise_after", auxVec(), 12'h004);
        checkOutput("aux_main_static", mainVec(), 12'h100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
